// File: rtl/debug_mem_loader.sv
// Byte-serial debug loader: a command stream writes or reads one word of InstRAM or DataRAM.
// Latency: writes reach the RAM 1 cycle after the last data byte; read data is captured 2 cycles after the last address byte.
// Backpressure: rx_ready is high only while collecting a command, and tx_valid holds its byte until tx_ready.
module debug_mem_loader #(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic        CPU_CLK,
  input  logic        CPU_RST,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic        busy,
  output logic [31:0] CPU_Debug_InstRAM_A2,
  output logic [31:0] CPU_Debug_InstRAM_WD2,
  output logic [3:0]  CPU_Debug_InstRAM_WE2,
  input  logic [31:0] CPU_Debug_InstRAM_RD2,
  output logic [31:0] CPU_Debug_DataRAM_A2,
  output logic [31:0] CPU_Debug_DataRAM_WD2,
  output logic [3:0]  CPU_Debug_DataRAM_WE2,
  input  logic [31:0] CPU_Debug_DataRAM_RD2
);

  // The abort fires on the idle cycle that would take the counter to TIMEOUT_CYCLES.
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_DATA, S_WRITE, S_RD_ADDR, S_RD_CAP, S_RESP
  } state_t;

  state_t      r_state, w_next;
  logic [1:0]  r_cnt;        // byte index within the addr/data field or the response
  logic [1:0]  r_resp_last;  // index of the final response byte
  logic [15:0] r_tmo;
  logic [31:0] r_addr, r_data, r_resp;
  logic        r_is_read, r_sel_dram;

  logic        w_rx_rdy, w_tx_vld, w_rx_acc, w_tx_acc;
  logic        w_in_frame, w_tmo_hit, w_opc_ok;
  logic [31:0] w_ram_a, w_ram_wd;
  logic [3:0]  w_ram_we;

  assign w_in_frame = (r_state == S_ADDR) || (r_state == S_DATA);
  assign w_rx_rdy   = !CPU_RST && ((r_state == S_IDLE) || w_in_frame);
  assign w_tx_vld   = !CPU_RST && (r_state == S_RESP);
  assign rx_ready   = w_rx_rdy;
  assign tx_valid   = w_tx_vld;
  assign w_rx_acc   = rx_valid && w_rx_rdy;
  assign w_tx_acc   = w_tx_vld && tx_ready;
  assign w_tmo_hit  = w_in_frame && !w_rx_acc && (r_tmo == TMO_LAST);
  assign w_opc_ok   = (rx_data == 8'h01) || (rx_data == 8'h02) ||
                      (rx_data == 8'h03) || (rx_data == 8'h04);

  // State register.
  always_ff @(posedge CPU_CLK) begin
    if (CPU_RST) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  // Next-state decode plus response byte, busy and RAM port steering.
  always_comb begin
    w_next   = r_state;
    tx_data  = 8'h00;
    busy     = !CPU_RST && (r_state != S_IDLE);
    w_ram_a  = 32'h0;
    w_ram_wd = 32'h0;
    w_ram_we = 4'h0;
    CPU_Debug_InstRAM_A2  = 32'h0;
    CPU_Debug_InstRAM_WD2 = 32'h0;
    CPU_Debug_InstRAM_WE2 = 4'h0;
    CPU_Debug_DataRAM_A2  = 32'h0;
    CPU_Debug_DataRAM_WD2 = 32'h0;
    CPU_Debug_DataRAM_WE2 = 4'h0;
    case (r_state)
      S_IDLE: begin
        if (w_rx_acc) w_next = w_opc_ok ? S_ADDR : S_RESP;
      end
      S_ADDR: begin
        if (w_rx_acc && (r_cnt == 2'd3)) w_next = r_is_read ? S_RD_ADDR : S_DATA;
        else if (w_tmo_hit)              w_next = S_RESP;
      end
      S_DATA: begin
        if (w_rx_acc && (r_cnt == 2'd3)) w_next = S_WRITE;
        else if (w_tmo_hit)              w_next = S_RESP;
      end
      S_WRITE: begin
        w_ram_a  = {r_addr[31:2], 2'b00};
        w_ram_wd = r_data;
        w_ram_we = 4'hF;
        w_next   = S_RESP;
      end
      S_RD_ADDR: begin
        w_ram_a = {r_addr[31:2], 2'b00};
        w_next  = S_RD_CAP;
      end
      S_RD_CAP: begin
        w_ram_a = {r_addr[31:2], 2'b00};
        w_next  = S_RESP;
      end
      S_RESP: begin
        if (w_tx_acc && (r_cnt == r_resp_last)) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
    if (w_tx_vld) begin
      case (r_cnt)
        2'd0:    tx_data = r_resp[7:0];
        2'd1:    tx_data = r_resp[15:8];
        2'd2:    tx_data = r_resp[23:16];
        default: tx_data = r_resp[31:24];
      endcase
    end
    if (!CPU_RST) begin
      if (r_sel_dram) begin
        CPU_Debug_DataRAM_A2  = w_ram_a;
        CPU_Debug_DataRAM_WD2 = w_ram_wd;
        CPU_Debug_DataRAM_WE2 = w_ram_we;
      end else begin
        CPU_Debug_InstRAM_A2  = w_ram_a;
        CPU_Debug_InstRAM_WD2 = w_ram_wd;
        CPU_Debug_InstRAM_WE2 = w_ram_we;
      end
    end
  end

  // Command assembly, idle timeout, read capture and response byte sequencing.
  always_ff @(posedge CPU_CLK) begin
    if (CPU_RST) begin
      r_cnt       <= 2'd0;
      r_resp_last <= 2'd0;
      r_tmo       <= 16'd0;
      r_addr      <= 32'h0;
      r_data      <= 32'h0;
      r_resp      <= 32'h0;
      r_is_read   <= 1'b0;
      r_sel_dram  <= 1'b0;
    end else begin
      r_tmo <= 16'd0;
      case (r_state)
        S_IDLE: begin
          r_cnt <= 2'd0;
          if (w_rx_acc) begin
            r_is_read  <= (rx_data == 8'h02) || (rx_data == 8'h04);
            r_sel_dram <= (rx_data == 8'h03) || (rx_data == 8'h04);
            if (!w_opc_ok) begin
              r_resp      <= 32'h0000_00EE;
              r_resp_last <= 2'd0;
            end
          end
        end
        S_ADDR, S_DATA: begin
          if (w_rx_acc) begin
            if (r_state == S_ADDR) r_addr[{r_cnt, 3'b000} +: 8] <= rx_data;
            else                   r_data[{r_cnt, 3'b000} +: 8] <= rx_data;
            r_cnt <= r_cnt + 2'd1;
          end else if (w_tmo_hit) begin
            // Drop the partial frame so nothing stale survives into the next command.
            r_addr      <= 32'h0;
            r_data      <= 32'h0;
            r_cnt       <= 2'd0;
            r_resp      <= 32'h0000_00EE;
            r_resp_last <= 2'd0;
          end else begin
            r_tmo <= r_tmo + 16'd1;
          end
        end
        S_WRITE: begin
          r_cnt       <= 2'd0;
          r_resp      <= 32'h0000_00AA;
          r_resp_last <= 2'd0;
        end
        S_RD_CAP: begin
          r_cnt       <= 2'd0;
          r_resp      <= r_sel_dram ? CPU_Debug_DataRAM_RD2 : CPU_Debug_InstRAM_RD2;
          r_resp_last <= 2'd3;
        end
        S_RESP: begin
          if (w_tx_acc) r_cnt <= (r_cnt == r_resp_last) ? 2'd0 : r_cnt + 2'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_debug_mem_loader.sv
// Bench for debug_mem_loader: directed scenarios then random commands against a word-level memory model.
// Responses are compared byte by byte; RAM port activity is logged by a monitor.
// tx_ready is stalled randomly and rx bytes are spaced with random gaps shorter than the timeout.
module tb_debug_mem_loader;
  localparam int TMO = 8;

  logic        CPU_CLK = 1'b0;
  logic        CPU_RST = 1'b1;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        tx_ready = 1'b0;
  logic        rx_ready, tx_valid, busy;
  logic [7:0]  tx_data;
  logic [31:0] i_a2, i_wd2, d_a2, d_wd2;
  logic [3:0]  i_we2, d_we2;
  logic [31:0] i_rd2, d_rd2;

  debug_mem_loader #(.TIMEOUT_CYCLES(TMO)) dut (
    .CPU_CLK(CPU_CLK), .CPU_RST(CPU_RST),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready), .busy(busy),
    .CPU_Debug_InstRAM_A2(i_a2), .CPU_Debug_InstRAM_WD2(i_wd2),
    .CPU_Debug_InstRAM_WE2(i_we2), .CPU_Debug_InstRAM_RD2(i_rd2),
    .CPU_Debug_DataRAM_A2(d_a2), .CPU_Debug_DataRAM_WD2(d_wd2),
    .CPU_Debug_DataRAM_WE2(d_we2), .CPU_Debug_DataRAM_RD2(d_rd2)
  );

  always #5 CPU_CLK = ~CPU_CLK;

  int n_checks = 0;
  int n_fail   = 0;

  // Initial contents of never-written words, shared by environment RAMs and reference model.
  function automatic logic [31:0] dflt(input bit ram, input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ (ram ? 32'h0F0F0F0F : 32'h5A5A5A5A);
  endfunction

  // Environment RAMs: synchronous read, data valid one cycle after the address.
  logic [31:0] env_imem [logic [31:0]];
  logic [31:0] env_dmem [logic [31:0]];
  always @(posedge CPU_CLK) begin
    i_rd2 <= env_imem.exists(i_a2) ? env_imem[i_a2] : dflt(1'b0, i_a2);
    d_rd2 <= env_dmem.exists(d_a2) ? env_dmem[d_a2] : dflt(1'b1, d_a2);
    if (i_we2 == 4'hF) env_imem[i_a2] = i_wd2;
    if (d_we2 == 4'hF) env_dmem[d_a2] = d_wd2;
  end

  // Reference model: word-addressed contents expected after each completed write command.
  logic [31:0] ref_imem [logic [31:0]];
  logic [31:0] ref_dmem [logic [31:0]];
  function automatic logic [31:0] ref_rd(input bit ram, input logic [31:0] a);
    if (ram) return ref_dmem.exists(a) ? ref_dmem[a] : dflt(1'b1, a);
    else     return ref_imem.exists(a) ? ref_imem[a] : dflt(1'b0, a);
  endfunction

  // Monitor of RAM port activity, sampled mid-cycle.
  typedef struct packed {
    logic        ram;
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  we;
  } wr_t;
  wr_t wlog[$];
  wr_t mon_rec;
  int  we_cycles = 0, both_cycles = 0, act_cycles = 0, d100_cycles = 0;
  always @(negedge CPU_CLK) begin
    if (i_we2 != 4'h0) begin
      we_cycles++;
      mon_rec = {1'b0, i_a2, i_wd2, i_we2};
      wlog.push_back(mon_rec);
    end
    if (d_we2 != 4'h0) begin
      we_cycles++;
      mon_rec = {1'b1, d_a2, d_wd2, d_we2};
      wlog.push_back(mon_rec);
    end
    if ((i_we2 != 4'h0) && (d_we2 != 4'h0)) both_cycles++;
    if (|{i_a2, i_wd2, i_we2, d_a2, d_wd2, d_we2}) act_cycles++;
    if (d_a2 == 32'h100) d100_cycles++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the byte was accepted.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    repeat (gap) @(negedge CPU_CLK);
    rx_valid = 1'b1;
    rx_data  = b;
    n = 0;
    while (!rx_ready && n < 50) begin
      @(negedge CPU_CLK);
      n++;
    end
    check("rx_accept_bound", n < 50, 1);
    @(posedge CPU_CLK);
    @(negedge CPU_CLK);
    rx_valid = 1'b0;
  endtask

  task automatic recv_resp(input int len, input logic [31:0] exp_word, input string tag);
    int n;
    for (int i = 0; i < len; i++) begin
      tx_ready = 1'b0;
      repeat ($urandom_range(0, 2)) @(negedge CPU_CLK);
      tx_ready = 1'b1;
      n = 0;
      while (!tx_valid && n < 50) begin
        @(negedge CPU_CLK);
        n++;
      end
      check("tx_valid_bound", n < 50, 1);
      check(tag, tx_data, exp_word[8*i +: 8]);
      @(posedge CPU_CLK);
      @(negedge CPU_CLK);
    end
    tx_ready = 1'b0;
  endtask

  task automatic run_cmd(input logic [7:0] op, input logic [31:0] addr,
                         input logic [31:0] data, input int gapmax);
    bit          is_wr, ram;
    logic [31:0] wa, exp;
    is_wr = (op == 8'h01) || (op == 8'h03);
    ram   = (op == 8'h03) || (op == 8'h04);
    wa    = {addr[31:2], 2'b00};
    wlog.delete();
    we_cycles = 0;
    send_byte(op, $urandom_range(0, gapmax));
    for (int i = 0; i < 4; i++) send_byte(addr[8*i +: 8], $urandom_range(0, gapmax));
    if (is_wr) begin
      for (int i = 0; i < 4; i++) send_byte(data[8*i +: 8], $urandom_range(0, gapmax));
      if (ram) ref_dmem[wa] = data;
      else     ref_imem[wa] = data;
      recv_resp(1, 32'hAA, "write_ack");
      check("write_count", wlog.size(), 1);
      check("we_cycles", we_cycles, 1);
      if (wlog.size() == 1) begin
        check("write_ram", wlog[0].ram, ram);
        check("write_addr", wlog[0].a, wa);
        check("write_data", wlog[0].d, data);
        check("write_we", wlog[0].we, 4'hF);
      end
    end else begin
      exp = ref_rd(ram, wa);
      recv_resp(4, exp, "read_byte");
      check("read_no_write", wlog.size(), 0);
    end
    check("idle_after_cmd", busy, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int          n;
    logic [31:0] exp;
    logic [31:0] addr;
    logic [7:0]  op;

    // Reset state
    repeat (3) @(negedge CPU_CLK);
    check("reset_outputs_zero",
          |{rx_ready, tx_valid, tx_data, busy, i_a2, i_wd2, i_we2, d_a2, d_wd2, d_we2}, 0);
    CPU_RST = 1'b0;
    @(negedge CPU_CLK);
    check("rx_ready_after_reset", rx_ready, 1);
    check("busy_after_reset", busy, 0);
    check("tx_valid_after_reset", tx_valid, 0);

    // Write DEADBEEF to InstRAM 0x10
    run_cmd(8'h01, 32'h10, 32'hDEADBEEF, 0);

    // Read DataRAM through an unaligned address; word 0x100 holds 12345678
    env_dmem[32'h100] = 32'h12345678;
    ref_dmem[32'h100] = 32'h12345678;
    d100_cycles = 0;
    run_cmd(8'h04, 32'h103, 32'h0, 0);
    check("dram_addr_cycles", d100_cycles, 2);

    // Invalid opcode
    act_cycles = 0;
    send_byte(8'h7F, 0);
    recv_resp(1, 32'hEE, "bad_opcode_resp");
    check("bad_opcode_no_ram", act_cycles, 0);
    check("bad_opcode_rx_ready", rx_ready, 1);

    // Stall mid-address until the timeout fires
    wlog.delete();
    we_cycles = 0;
    send_byte(8'h03, 0);
    send_byte(8'h00, 0);
    n = 0;
    while (!tx_valid && n < 40) begin
      @(negedge CPU_CLK);
      n++;
    end
    check("timeout_cycles", n, TMO);
    recv_resp(1, 32'hEE, "timeout_resp");
    check("timeout_no_we", we_cycles, 0);

    // Response stalled by tx_ready while a new byte is offered
    exp = ref_rd(1'b0, 32'h10);
    send_byte(8'h02, 0);
    for (int i = 0; i < 4; i++) send_byte(8'((32'h10 >> (8*i))), 0);
    n = 0;
    while (!tx_valid && n < 20) begin
      @(negedge CPU_CLK);
      n++;
    end
    check("stall_tx_bound", n < 20, 1);
    rx_valid = 1'b1;
    rx_data  = 8'h01;
    for (int i = 0; i < 5; i++) begin
      check("stall_tx_data_held", tx_data, exp[7:0]);
      check("stall_rx_not_ready", rx_ready, 0);
      @(posedge CPU_CLK);
      @(negedge CPU_CLK);
    end
    rx_valid = 1'b0;
    recv_resp(4, exp, "stall_read_byte");
    check("stall_byte_not_taken", busy, 0);

    // Reset during the third data byte
    wlog.delete();
    we_cycles = 0;
    send_byte(8'h03, 0);
    for (int i = 0; i < 4; i++) send_byte(8'((32'h40 >> (8*i))), 0);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    rx_valid = 1'b1;
    rx_data  = 8'h33;
    CPU_RST  = 1'b1;
    #1;
    check("midcmd_reset_outputs_zero",
          |{rx_ready, tx_valid, tx_data, busy, i_a2, i_wd2, i_we2, d_a2, d_wd2, d_we2}, 0);
    @(negedge CPU_CLK);
    @(negedge CPU_CLK);
    check("midcmd_reset_held_zero",
          |{rx_ready, tx_valid, tx_data, busy, i_a2, i_wd2, i_we2, d_a2, d_wd2, d_we2}, 0);
    rx_valid = 1'b0;
    CPU_RST  = 1'b0;
    @(negedge CPU_CLK);
    check("midcmd_reset_no_write", we_cycles, 0);
    check("midcmd_reset_idle", busy, 0);
    run_cmd(8'h03, 32'h40, 32'hCAFEF00D, 0);
    run_cmd(8'h04, 32'h40, 32'h0, 0);

    // Random commands against the reference model
    for (int k = 0; k < 24; k++) begin
      op   = 8'($urandom_range(1, 4));
      addr = 32'($urandom_range(0, 63));
      if ($urandom_range(0, 1) == 1) addr[31] = 1'b1;
      run_cmd(op, addr, $urandom, 3);
    end

    check("never_both_we", both_cycles, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/debug_mem_loader.md
DEBUG_MEM_LOADER -- requirements
Module: debug_mem_loader

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 50000, max idle cycles between command bytes before the command is aborted (16-bit counter range).
REQ-002 Port: CPU_CLK  input  1  sole clock; all state updates on its rising edge.
REQ-003 Port: CPU_RST  input  1  reset; synchronous, active-high.
REQ-004 Port: rx_valid  input  1  command byte available.
REQ-005 Port: rx_data  input  8  command byte.
REQ-006 Port: rx_ready  output  1  command byte accepted when rx_valid && rx_ready.
REQ-007 Port: tx_valid  output  1  response byte available.
REQ-008 Port: tx_data  output  8  response byte.
REQ-009 Port: tx_ready  input  1  response byte consumed when tx_valid && tx_ready.
REQ-010 Port: busy  output  1  high in every state except IDLE.
REQ-011 Port: CPU_Debug_InstRAM_A2 / _WD2 / _WE2  output  32/32/4  instruction RAM debug port address, write data and byte write-enables.
REQ-012 Port: CPU_Debug_InstRAM_RD2  input  32  instruction RAM debug read data, valid one cycle after the address.
REQ-013 Port: CPU_Debug_DataRAM_A2 / _WD2 / _WE2  output  32/32/4  data RAM debug port, same meaning as REQ-011.
REQ-014 Port: CPU_Debug_DataRAM_RD2  input  32  data RAM debug read data, same timing as REQ-012.

Function
REQ-015 Command frame, LSB byte first: opcode byte, then 4 address bytes, then 4 data bytes (write opcodes only).
REQ-016 Opcodes: 0x01 = write InstRAM, 0x02 = read InstRAM, 0x03 = write DataRAM, 0x04 = read DataRAM.
REQ-017 States: IDLE, ADDR, DATA, WRITE, RD_ADDR, RD_CAP, RESP.
REQ-018 rx_ready SHALL be 1 only in IDLE, ADDR and DATA; tx_valid SHALL be 1 only in RESP.
REQ-019 IDLE: an accepted valid opcode -> ADDR with byte count 0; an accepted invalid opcode -> RESP with the single byte 0xEE.
REQ-020 ADDR: 4 accepted bytes fill addr[7:0] to addr[31:24]; after the 4th, write opcodes -> DATA and read opcodes -> RD_ADDR.
REQ-021 DATA: 4 accepted bytes fill data LSB first; after the 4th -> WRITE.
REQ-022 WRITE, exactly 1 cycle: the selected RAM gets A2 = {addr[31:2],2'b00}, WD2 = data, WE2 = 4'hF; then RESP with the single byte 0xAA.
REQ-023 RD_ADDR, 1 cycle: the selected RAM gets A2 = {addr[31:2],2'b00} with WE2 = 0; then RD_CAP.
REQ-024 RD_CAP, 1 cycle: A2 is held; the selected RD2 is latched into the response register; then RESP with 4 bytes, LSB first.
REQ-025 RESP: tx_data and tx_valid stay stable until tx_ready; each handshake advances one byte; after the last byte -> IDLE.
REQ-026 The non-selected RAM port, and both ports outside WRITE/RD_ADDR/RD_CAP, SHALL drive A2 = 0, WD2 = 0, WE2 = 0.
REQ-027 WE2 SHALL never be nonzero in more than one cycle per write command, and never on both RAMs at once.
REQ-028 Timeout counter: cleared on every accepted byte and in every state other than ADDR/DATA.
REQ-029 Timeout counter: increments each ADDR/DATA cycle without an accepted byte.
REQ-030 When the counter reaches TIMEOUT_CYCLES: discard the partial command, then RESP with the single byte 0xEE; no RAM access occurs.
REQ-031 rx_valid asserted outside IDLE/ADDR/DATA is not consumed; the byte stays pending for the upstream source.

Reset
REQ-032 While CPU_RST = 1 at a clock edge: state -> IDLE; byte count, timeout counter, addr, data and response register -> 0.
REQ-033 While CPU_RST = 1: rx_ready = 0, tx_valid = 0, tx_data = 0, busy = 0, and all A2/WD2/WE2 outputs = 0.
REQ-034 Reset asserted mid-command or mid-response SHALL abort with no RAM write issued after the reset edge.
REQ-035 rx_ready SHALL be 1 in the first cycle after reset deasserts.

Verification
REQ-036 Send 01 10 00 00 00 EF BE AD DE -> exactly one cycle with InstRAM_A2 = 0x10, WD2 = 0xDEADBEEF, WE2 = F; then tx 0xAA.
REQ-037 Send 04 03 01 00 00 with DataRAM model returning 0x12345678 at 0x100 -> DataRAM_A2 = 0x100 for 2 cycles, WE2 = 0; tx 78 56 34 12.
REQ-038 Send 0x7F -> tx 0xEE; no RAM activity; rx_ready high again after the byte is consumed.
REQ-039 Send 03 00 and then stall (TIMEOUT_CYCLES = 8) -> after 8 idle cycles tx 0xEE; WE2 stays 0 throughout.
REQ-040 Read response with tx_ready low for 5 cycles -> tx_data held at byte 0; rx_valid high meanwhile is not accepted.
REQ-041 Assert CPU_RST during DATA byte 3 -> all outputs 0; a subsequent full write command executes normally.
